// File: rtl/tpu_sram_pkg.sv
// tpu_sram_pkg: shared state encoding and default parameters for the SRAM read streamer
package tpu_sram_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_LEN_WIDTH  = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} rd_stream_state_e;
endpackage

// File: rtl/tpu_stream_fifo.sv
// tpu_stream_fifo: synchronous first-word-fall-through FIFO with occupancy count
module tpu_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (cnt_q != CW'(DEPTH) || do_pop);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/tpu_sram_rd_streamer.sv
// tpu_sram_rd_streamer: turns strided burst descriptors into SRAM reads and a
// back-pressured beat stream, throttling reads so returning data always has a FIFO slot.
module tpu_sram_rd_streamer
  import tpu_sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  sram_rd_en,
  output logic [ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [DATA_WIDTH-1:0] sram_rd_data,
  input  logic                  sram_rd_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] FD = (CW + 1)'(FIFO_DEPTH);
  rd_stream_state_e state_q;
  logic [ADDR_WIDTH-1:0] addr_q, stride_q;
  logic [LEN_WIDTH-1:0] len_q, issued_q, beat_q;
  logic [CW-1:0] outst_q, fifo_cnt;
  logic [DATA_WIDTH-1:0] head;
  logic [CW:0] credit;
  logic push, pop, empty;
  tpu_stream_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .data_i(sram_rd_data),
    .pop_i(pop), .data_o(head), .empty_o(empty), .count_o(fifo_cnt)
  );
  // Data returning without a matching outstanding read (e.g. across a reset) is dropped.
  assign push = sram_rd_valid && outst_q != '0;
  assign pop = out_valid && out_ready;
  // A slot freed by this cycle's pop is reusable: the read issued now lands next cycle at the earliest.
  assign credit = {1'b0, outst_q} + {1'b0, fifo_cnt} - {{CW{1'b0}}, pop};
  assign sram_rd_en = state_q == ISSUE && credit < FD;
  assign sram_rd_addr = addr_q;
  assign out_valid = !empty;
  assign out_data = empty ? '0 : head;
  assign out_last = out_valid && beat_q == len_q - 1'b1;
  assign busy = state_q != IDLE;
  assign done = state_q == FINISH;
  assign cmd_ready = rst_n && state_q == IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      issued_q <= '0;
      beat_q   <= '0;
      outst_q  <= '0;
    end else begin
      outst_q <= outst_q + CW'(sram_rd_en) - CW'(push);
      if (pop) beat_q <= beat_q + 1'b1;
      case (state_q)
        IDLE: if (cmd_valid) begin
          addr_q   <= cmd_base;
          stride_q <= cmd_stride;
          len_q    <= cmd_len;
          issued_q <= '0;
          beat_q   <= '0;
          state_q  <= cmd_len == '0 ? FINISH : ISSUE;
        end
        ISSUE: if (sram_rd_en) begin
          addr_q   <= addr_q + stride_q;
          issued_q <= issued_q + 1'b1;
          if (issued_q == len_q - 1'b1) state_q <= DRAIN;
        end
        DRAIN: if (pop && out_last) state_q <= FINISH;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tpu_sram_rd_streamer.sv
// tb_tpu_sram_rd_streamer: scoreboard bench with directed bursts against an SRAM model where mem[i]=i
module tb_tpu_sram_rd_streamer;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [9:0] cmd_base = 0, cmd_stride = 0;
  logic [15:0] cmd_len = 0;
  logic sram_rd_en, sram_rd_valid, mv = 0, spur = 0;
  logic [9:0] sram_rd_addr;
  logic [31:0] sram_rd_data = 0, out_data;
  logic out_valid, out_ready = 1, out_last, busy, done;
  int cyc = 0, pass_cnt = 0, tot_cnt = 0;
  int rd_cnt = 0, ov_cnt = 0, done_cnt = 0, first_ov = -1, first_rd = -1, acc = 0;
  int rd0, ov0, dn0, dcyc;
  logic prev_stall = 0, prev_l = 0;
  logic [31:0] prev_d = 0;
  logic [32:0] eq[$];
  logic [9:0] aq[$];

  tpu_sram_rd_streamer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
    .sram_rd_valid(sram_rd_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    mv <= sram_rd_en;
    sram_rd_data <= 32'(sram_rd_addr);
  end
  assign sram_rd_valid = mv | spur;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
  endtask

  task automatic mon();
    logic [32:0] e;
    if (!rst_n) begin
      prev_stall = 0;
      return;
    end
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_d);
      chk("hold_last", out_last, prev_l);
    end
    if (sram_rd_en) begin
      rd_cnt++;
      if (first_rd <= acc) first_rd = cyc;
      if (aq.size() == 0) chk("unexpected_rd", sram_rd_en, 0);
      else chk("rd_addr", sram_rd_addr, aq.pop_front());
    end
    if (out_valid) begin
      ov_cnt++;
      if (first_ov <= acc) first_ov = cyc;
    end
    if (out_valid && out_ready) begin
      if (eq.size() == 0) chk("unexpected_beat", out_valid, 0);
      else begin
        e = eq.pop_front();
        chk("beat_data", out_data, e[31:0]);
        chk("beat_last", out_last, e[32]);
      end
    end
    if (done) done_cnt++;
    prev_stall = out_valid && !out_ready;
    prev_d = out_data;
    prev_l = out_last;
  endtask

  task automatic start(input logic [9:0] b, input logic [9:0] s, input logic [15:0] l);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < int'(l); i++) begin
      logic [9:0] a;
      a = b + 10'(i) * s;
      aq.push_back(a);
      eq.push_back({i == int'(l) - 1, 32'(a)});
    end
    rd0 = rd_cnt;
    ov0 = ov_cnt;
    dn0 = done_cnt;
    acc = cyc;
    cmd_valid = 1;
    cmd_base = b;
    cmd_stride = s;
    cmd_len = l;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_done(input bit tog);
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      if (tog) out_ready = ~out_ready;
      n++;
    end
    if (!done) chk("done_timeout", done, 1);
    dcyc = cyc;
    @(negedge clk);
    out_ready = 1;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("ready_after_done", cmd_ready, 1);
    chk("leftover_beats", eq.size(), 0);
    chk("leftover_addrs", aq.size(), 0);
    chk("done_count", done_cnt - dn0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag, input logic rdy);
    chk({tag, "_cmd_ready"}, cmd_ready, rdy);
    chk({tag, "_rd_en"}, sram_rd_en, 0);
    chk({tag, "_rd_addr"}, sram_rd_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    #1;
    chk_reset_outputs("rst", 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk("ready_after_rst", cmd_ready, 1);
    fork
      forever begin
        @(negedge clk);
        #1 mon();
      end
      begin
        // stray read data while idle must not create a beat
        @(negedge clk);
        spur = 1;
        @(negedge clk);
        spur = 0;
        @(negedge clk);
        chk("stray_valid_ignored", out_valid, 0);
        // base 0x10, stride 1, len 4: rd at cycle 1, first beat cycle 3, done cycle 7
        start(10'h010, 10'd1, 16'd4);
        wait_done(0);
        chk("lat_first_rd", first_rd - acc, 1);
        chk("lat_first_beat", first_ov - acc, 3);
        chk("lat_done", dcyc - acc, 7);
        chk("reads_len4", rd_cnt - rd0, 4);
        // address wrap 0x3FE,0x3FF,0x000,0x001
        start(10'h3FE, 10'd1, 16'd4);
        wait_done(0);
        chk("reads_wrap", rd_cnt - rd0, 4);
        // stalled sink: only FIFO_DEPTH reads may be in flight
        out_ready = 0;
        start(10'h100, 10'd5, 16'd8);
        repeat (20) @(negedge clk);
        chk("stall_reads", rd_cnt - rd0, 4);
        chk("stall_valid", out_valid, 1);
        out_ready = 1;
        wait_done(0);
        chk("reads_len8", rd_cnt - rd0, 8);
        // zero-length burst
        start(10'h055, 10'd1, 16'd0);
        wait_done(0);
        chk("len0_done_lat", dcyc - acc, 1);
        chk("len0_no_reads", rd_cnt - rd0, 0);
        chk("len0_no_beats", ov_cnt - ov0, 0);
        // toggling ready, stride 3
        out_ready = 1;
        start(10'h020, 10'd3, 16'd6);
        wait_done(1);
        chk("reads_stride3", rd_cnt - rd0, 6);
        // reset after two beats of an 8-beat burst
        begin
          int n = 0;
          start(10'h200, 10'd1, 16'd8);
          while (eq.size() > 6 && n < 50) begin
            @(negedge clk);
            n++;
          end
          chk("beats_before_reset", eq.size(), 6);
          rst_n = 0;
          #1 chk_reset_outputs("midrst", 0);
          eq.delete();
          aq.delete();
          repeat (2) @(negedge clk);
          rst_n = 1;
          repeat (4) @(negedge clk);
          chk("no_done_after_reset", done_cnt - dn0, 0);
          chk_reset_outputs("post_rst", 1);
        end
        start(10'h080, 10'd2, 16'd3);
        wait_done(0);
        chk("reads_after_reset", rd_cnt - rd0, 3);
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/tpu_sram_rd_streamer.md
TPU_SRAM_RD_STREAMER -- requirements
Module: tpu_sram_rd_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, SRAM word and stream beat width.
REQ-002 SHALL have parameter DEPTH, default 1024, SRAM words addressed.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), SRAM address width.
REQ-004 SHALL have parameter LEN_WIDTH, default 16, burst length field width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4 (legal >=2, power of two), output buffer entries.
REQ-006 SHALL have ports, in order:
- clk  in  1  clock; reset rst_n, asynchronous, active-low; clock clk.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  burst descriptor valid.
- cmd_ready  out  1  descriptor accepted when cmd_valid&cmd_ready.
- cmd_base  in  ADDR_WIDTH  first word address.
- cmd_stride  in  ADDR_WIDTH  address increment per beat.
- cmd_len  in  LEN_WIDTH  beat count; 0 legal.
- sram_rd_en  out  1  1R1W SRAM read strobe.
- sram_rd_addr  out  ADDR_WIDTH  SRAM read address.
- sram_rd_data  in  DATA_WIDTH  SRAM read data, 1 cycle after sram_rd_en.
- sram_rd_valid  in  1  SRAM read-data valid, 1 cycle after sram_rd_en.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  stream sink ready.
- out_data  out  DATA_WIDTH  stream beat.
- out_last  out  1  final beat of burst.
- busy  out  1  high from descriptor accept until done.
- done  out  1  one-cycle pulse at burst completion.

Function
REQ-007 SHALL implement states IDLE, ISSUE, DRAIN, FINISH.
REQ-008 IDLE: cmd_ready=1; on accept with cmd_len>0 latch base/stride/len, go ISSUE; with cmd_len==0 go FINISH, no SRAM read, no beat.
REQ-009 ISSUE: assert sram_rd_en only when outstanding (issued, not yet returned) + FIFO occupancy < FIFO_DEPTH; no beat is ever dropped.
REQ-010 First read address SHALL be cmd_base; each subsequent addr = previous + stride, modulo 2^ADDR_WIDTH (wrap, no error).
REQ-011 After cmd_len reads issued, SHALL go DRAIN; DRAIN exits to FINISH on the cycle the last beat handshakes (out_valid&out_ready&out_last).
REQ-012 FINISH: done=1 for exactly one cycle, busy=0 from next cycle, return IDLE; cmd_ready=0 in all states except IDLE.
REQ-013 sram_rd_valid SHALL push sram_rd_data into FIFO; FIFO head drives out_data, out_valid=FIFO non-empty.
REQ-014 Push and pop in same cycle SHALL keep occupancy; occupancy never exceeds FIFO_DEPTH.
REQ-015 out_last SHALL be 1 exactly on beat number cmd_len (beat counter separate from issue counter).
REQ-016 out_data/out_valid/out_last SHALL hold stable while out_valid&!out_ready.
REQ-017 Minimum latency: accept at cycle 0 -> sram_rd_en cycle 1 -> out_valid cycle 3; with out_ready=1 throughput 1 beat/cycle.
REQ-018 sram_rd_valid arriving with no outstanding read SHALL be ignored.

Reset
REQ-019 rst_n low SHALL force IDLE, FIFO empty, counters 0, outstanding 0.
REQ-020 Reset values: cmd_ready=1 (0 while rst_n low), sram_rd_en=0, sram_rd_addr=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
REQ-021 Reset mid-burst SHALL discard remaining beats; no done pulse.

Structure
REQ-022 Package tpu_sram_pkg SHALL hold state enum rd_stream_state_e and default parameter constants.
REQ-023 FIFO SHALL be sub-module tpu_stream_fifo (sync, first-word-fall-through, count output).

Verification
REQ-024 base=0x010, stride=1, len=4, out_ready=1, mem[i]=i -> beats 0x10..0x13 cycles 3-6, out_last on 0x13, done cycle 7.
REQ-025 base=0x3FE, stride=1, len=4 -> addrs 0x3FE,0x3FF,0x000,0x001 in order.
REQ-026 len=8, out_ready=0 for 20 cycles then 1 -> exactly FIFO_DEPTH reads issued before stall, all 8 beats delivered in order, none lost.
REQ-027 len=0 -> no sram_rd_en, no out_valid, done pulse one cycle after accept.
REQ-028 out_ready toggling 1010..., stride=3, len=6 -> data stable while stalled, last on beat 6, single done.
REQ-029 rst_n low at beat 2 of len=8 -> all outputs to reset values, next descriptor runs cleanly.
